// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM states, NOP encoding, control-flow opcodes.
package fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OPC_W   = 7;
   localparam int unsigned F3_W    = 3;

   localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0013;
   localparam logic [OPC_W-1:0]   OPC_BRANCH = 7'h63;
   localparam logic [OPC_W-1:0]   OPC_JAL    = 7'h6F;
   localparam logic [OPC_W-1:0]   OPC_JALR   = 7'h67;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_HALT = 2'd3
   } state_t;

   // Fields handed to the decoder
   typedef struct packed {
      logic             funct7;
      logic [F3_W-1:0]  funct3;
      logic [OPC_W-1:0] opcode;
   } dec_fields_t;

   function automatic dec_fields_t decode_fields(input logic [INSTR_W-1:0] ins);
      dec_fields_t f;
      f.funct7 = ins[30];
      f.funct3 = ins[14:12];
      f.opcode = ins[6:0];
      return f;
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a valid/ready port,
// holds each instruction until retirement, then steps or redirects.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = '0,
   parameter int unsigned       CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [XLEN-1:0]     imem_addr,
   input  logic                imem_rsp_valid,
   input  logic [INSTR_W-1:0]  imem_rsp_data,
   output logic [INSTR_W-1:0]  instr,
   output logic [OPC_W-1:0]    opcode,
   output logic [F3_W-1:0]     funct3,
   output logic                funct7,
   output logic                instr_valid,
   output logic [XLEN-1:0]     pc,
   output logic [XLEN-1:0]     pc_plus4,
   input  logic                instr_ack,
   input  logic                pc_src,
   input  logic [XLEN-1:0]     pc_target,
   output logic                halted,
   output logic [CNT_W-1:0]    instret
);

   state_t              r_state;
   logic [XLEN-1:0]     r_pc;
   logic [INSTR_W-1:0]  r_instr;
   logic [CNT_W-1:0]    r_instret;
   logic                r_req_valid;
   logic                r_instr_valid;
   logic                r_halted;

   state_t              w_state_nxt;
   logic [XLEN-1:0]     w_pc_nxt;
   logic [INSTR_W-1:0]  w_instr_nxt;
   logic [CNT_W-1:0]    w_instret_nxt;
   logic [XLEN-1:0]     w_pc_plus4;
   dec_fields_t         w_dec;

   assign w_pc_plus4 = r_pc + XLEN'(4);
   assign w_dec      = decode_fields(r_instr);

   // State and registered-output update; reset aborts any outstanding fetch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_REQ;
         r_pc          <= RESET_PC;
         r_instr       <= NOP_INSTR;
         r_instret     <= '0;
         r_req_valid   <= 1'b0;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_instr       <= w_instr_nxt;
         r_instret     <= w_instret_nxt;
         r_req_valid   <= (w_state_nxt == S_REQ);
         r_instr_valid <= (w_state_nxt == S_HOLD);
         r_halted      <= (w_state_nxt == S_HALT);
      end
   end

   // Next-state, next-PC mux and instruction capture
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_instr_nxt   = r_instr;
      w_instret_nxt = r_instret;
      unique case (r_state)
         S_REQ: begin
            if (r_req_valid && imem_req_ready) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               w_instr_nxt = imem_rsp_data;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (instr_ack) begin
               w_instret_nxt = r_instret + CNT_W'(1);
               if (!pc_src) begin
                  w_pc_nxt    = w_pc_plus4;
                  w_state_nxt = S_REQ;
               end else if (pc_target[1:0] == 2'b00) begin
                  w_pc_nxt    = pc_target;
                  w_state_nxt = S_REQ;
               end else begin
                  w_state_nxt = S_HALT;
               end
            end
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_REQ;
         end
      endcase
   end

   assign imem_req_valid = r_req_valid;
   assign imem_addr      = r_pc;
   assign instr          = r_instr;
   assign instr_valid    = r_instr_valid;
   assign pc             = r_pc;
   assign pc_plus4       = w_pc_plus4;
   assign halted         = r_halted;
   assign instret        = r_instret;
   assign opcode         = w_dec.opcode;
   assign funct3         = w_dec.funct3;
   assign funct7         = w_dec.funct7;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// and a randomized run checked against an architectural PC/retire model.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_ack;
   logic        pc_src;
   logic [31:0] pc_target;
   logic        halted;
   logic [31:0] instret;

   always #5 clk = ~clk;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .instr(instr), .opcode(opcode),
      .funct3(funct3), .funct7(funct7), .instr_valid(instr_valid),
      .pc(pc), .pc_plus4(pc_plus4), .instr_ack(instr_ack), .pc_src(pc_src),
      .pc_target(pc_target), .halted(halted), .instret(instret)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Memory-model configuration (written by the main sequence only)
   int rdy_pct   = 100;
   int lat_min   = 1;
   int lat_max   = 1;
   int spur_want = 0;

   // Memory-model state (written by the memory process only)
   int          spur_done = 0;
   int          pending   = 0;
   int          hs_cnt    = 0;
   logic [31:0] last_hs_addr = 32'hFFFF_FFFF;
   logic [31:0] pend_addr;

   // Instruction memory contents as a pure function of address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] h;
      logic [6:0]  op;
      if (a == 32'h0) return 32'h0050_0093;
      h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      case (h[10:8])
         3'd0:    op = OPC_BRANCH;
         3'd1:    op = OPC_JAL;
         3'd2:    op = OPC_JALR;
         3'd3:    op = 7'h33;
         default: op = 7'h13;
      endcase
      return {h[31:7], op};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory: acts half a cycle away from the active edge
   initial begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      forever begin
         @(negedge clk); #1;
         imem_rsp_valid = 1'b0;
         if (spur_want != spur_done) begin
            spur_done      = spur_want;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
         end else if (pending > 0) begin
            pending = pending - 1;
            if (pending == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(pend_addr);
            end
         end
         imem_req_ready = (32'($urandom_range(99)) < 32'(rdy_pct));
         if (imem_req_valid && imem_req_ready && !rst) begin
            hs_cnt++;
            last_hs_addr = imem_addr;
            pend_addr    = imem_addr;
            pending      = int'($urandom_range(lat_max, lat_min));
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      instr_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits for instr_valid; gap = count of low negedges including the one after ack
   task automatic wait_valid(output int gap);
      bit ok = 1'b0;
      gap = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (instr_valid) begin
            ok  = 1'b1;
            gap = i + 1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_valid: instr_valid never rose (timeout) at %0t", $time);
      end
   endtask

   task automatic check_hold(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
      logic [31:0] w;
      w = mem_word(exp_pc);
      chk({tag, ".valid"},  32'(instr_valid), 32'd1);
      chk({tag, ".pc"},     pc, exp_pc);
      chk({tag, ".fetch"},  last_hs_addr, exp_pc);
      chk({tag, ".instr"},  instr, w);
      chk({tag, ".opcode"}, 32'(opcode), 32'(w[6:0]));
      chk({tag, ".funct3"}, 32'(funct3), 32'(w[14:12]));
      chk({tag, ".funct7"}, 32'(funct7), 32'(w[30]));
      chk({tag, ".pc4"},    pc_plus4, exp_pc + 32'd4);
      chk({tag, ".instret"}, instret, exp_cnt);
      chk({tag, ".halted"}, 32'(halted), 32'd0);
   endtask

   // Retire the held instruction; ack lasts exactly one cycle
   task automatic do_ack(input bit src, input logic [31:0] tgt);
      instr_ack = 1'b1;
      pc_src    = src;
      pc_target = tgt;
      @(negedge clk);
      instr_ack = 1'b0;
      pc_src    = 1'($urandom);
      pc_target = $urandom;
      chk("ack.valid_drop", 32'(instr_valid), 32'd0);
   endtask

   typedef struct {
      bit          src;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
      bit          exp_halt;
   } vec_t;

   vec_t tv[10];

   initial begin
      int          gap;
      int          hs0;
      logic [31:0] mdl_pc;
      logic [31:0] mdl_cnt;
      bit          src;
      logic [31:0] tgt;

      rst = 1'b1; instr_ack = 1'b0; pc_src = 1'b0; pc_target = 32'h0;

      tv[0] = '{1'b0, 32'h0,         32'h4,         1'b0};
      tv[1] = '{1'b0, 32'h0,         32'h8,         1'b0};
      tv[2] = '{1'b0, 32'h0,         32'hC,         1'b0};
      tv[3] = '{1'b1, 32'h100,       32'h100,       1'b0};
      tv[4] = '{1'b0, 32'h0,         32'h104,       1'b0};
      tv[5] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
      tv[6] = '{1'b0, 32'h0,         32'h0,         1'b0};
      tv[7] = '{1'b0, 32'h0,         32'h4,         1'b0};
      tv[8] = '{1'b1, 32'h102,       32'h4,         1'b1};
      tv[9] = '{1'b1, 32'h101,       32'h4,         1'b1};

      // Reset state
      do_reset();
      chk("rst.pc",        pc, 32'h0);
      chk("rst.instr",     instr, 32'h0000_0013);
      chk("rst.valid",     32'(instr_valid), 32'd0);
      chk("rst.req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst.halted",    32'(halted), 32'd0);
      chk("rst.instret",   instret, 32'd0);

      // First fetch at RESET_PC
      wait_valid(gap);
      check_hold("first", 32'h0, 32'd0);
      chk("first.opcode_lit", 32'(opcode), 32'h13);
      chk("first.funct3_lit", 32'(funct3), 32'h0);
      chk("first.pc4_lit",    pc_plus4, 32'h4);

      // Directed table with single-cycle memory
      mdl_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         mdl_pc = pc;
         do_ack(tv[i].src, tv[i].tgt);
         mdl_cnt++;
         if (!tv[i].exp_halt) begin
            wait_valid(gap);
            chk($sformatf("vec%0d.gap", i), 32'(gap), 32'd2);
            check_hold($sformatf("vec%0d", i), tv[i].exp_pc, mdl_cnt);
         end else begin
            hs0 = hs_cnt;
            for (int c = 0; c < 5; c++) begin
               chk($sformatf("halt%0d.halted", c), 32'(halted), 32'd1);
               chk($sformatf("halt%0d.req", c),    32'(imem_req_valid), 32'd0);
               chk($sformatf("halt%0d.valid", c),  32'(instr_valid), 32'd0);
               chk($sformatf("halt%0d.pc", c),     pc, tv[i].exp_pc);
               @(negedge clk);
            end
            chk("halt.no_fetch", 32'(hs_cnt - hs0), 32'd0);
            chk("halt.instret",  instret, mdl_cnt);
         end
      end

      // Reset leaves the halt and restarts at RESET_PC
      do_reset();
      wait_valid(gap);
      check_hold("restart", 32'h0, 32'd0);

      // Misaligned target by one byte also halts
      do_ack(tv[9].src, tv[9].tgt);
      chk("halt1.halted", 32'(halted), 32'd1);
      chk("halt1.pc",     pc, 32'h0);

      // Request stalled by ready=0 with a spurious response in S_REQ
      do_reset();
      rdy_pct = 0;
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d.req", c),   32'(imem_req_valid), 32'd1);
         chk($sformatf("stall%0d.addr", c),  imem_addr, 32'h0);
         chk($sformatf("stall%0d.valid", c), 32'(instr_valid), 32'd0);
         if (c == 2) spur_want++;
         @(negedge clk);
      end
      chk("stall.instr_nop", instr, 32'h0000_0013);
      rdy_pct = 100;
      wait_valid(gap);
      check_hold("stall", 32'h0, 32'd0);

      // Reset while waiting on a slow response; stale response arrives in S_REQ
      do_ack(1'b0, 32'h0);
      wait_valid(gap);
      check_hold("pre_rst", 32'h4, 32'd1);
      lat_min = 6; lat_max = 6;
      hs0 = hs_cnt;
      do_ack(1'b0, 32'h0);
      for (int c = 0; c < 20 && hs_cnt == hs0; c++) @(negedge clk);
      chk("wait_rst.fetch", last_hs_addr, 32'h8);
      rst = 1'b1; rdy_pct = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20 && pending != 0; c++) @(negedge clk);
      @(negedge clk);
      chk("stale.valid",   32'(instr_valid), 32'd0);
      chk("stale.instr",   instr, 32'h0000_0013);
      chk("stale.req",     32'(imem_req_valid), 32'd1);
      chk("stale.addr",    imem_addr, 32'h0);
      chk("stale.instret", instret, 32'd0);
      lat_min = 1; lat_max = 1; rdy_pct = 100;
      wait_valid(gap);
      check_hold("after_stale", 32'h0, 32'd0);

      // Randomized run against the architectural model
      do_reset();
      rdy_pct = 60; lat_min = 1; lat_max = 4;
      mdl_pc = 32'h0; mdl_cnt = 32'h0;
      wait_valid(gap);
      for (int n = 0; n < 300; n++) begin
         check_hold($sformatf("rnd%0d", n), mdl_pc, mdl_cnt);
         repeat ($urandom_range(3)) begin
            @(negedge clk);
            chk("rnd.hold_valid", 32'(instr_valid), 32'd1);
            chk("rnd.hold_instr", instr, mdl_word(mdl_pc));
         end
         src = ($urandom_range(2) == 0);
         tgt = {$urandom_range(32'hFFFF_FFFF) & 32'hFFFF_FFFC};
         do_ack(src, tgt);
         mdl_cnt = mdl_cnt + 32'd1;
         mdl_pc  = src ? tgt : mdl_pc + 32'd4;
         wait_valid(gap);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   function automatic logic [31:0] mdl_word(input logic [31:0] a);
      return mem_word(a);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
      $fatal(1, "watchdog");
   end

endmodule
